// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_frame_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WRITE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bits per frame: address, data and an optional trailing parity bit.
  function automatic int frame_w(input int aw, input int dw, input bit par);
    return aw + dw + (par ? 1 : 0);
  endfunction

endpackage

// File: rtl/frame_shift_reg.sv
// MSB-first serial-to-parallel shifter with a bit counter.
// 'last' flags that the next shifted bit completes the frame; 'full' that it is complete.
module frame_shift_reg #(
  parameter int FRAME_W = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               shift,
  input  logic               sd,
  output logic [FRAME_W-1:0] data,
  output logic               last,
  output logic               full
);

  localparam int CW = $clog2(FRAME_W + 1);

  logic [CW-1:0]      count_reg;
  logic [FRAME_W-1:0] data_reg;
  logic [FRAME_W-1:0] data_next;

  assign data_next[0] = sd;
  for (genvar gi = 1; gi < FRAME_W; gi++) begin : g_shift
    assign data_next[gi] = data_reg[gi-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      data_reg  <= '0;
    end else if (start) begin
      count_reg <= CW'(1);
      data_reg  <= data_next;
    end else if (shift) begin
      count_reg <= count_reg + CW'(1);
      data_reg  <= data_next;
    end
  end

  assign data = data_reg;
  assign last = (count_reg == CW'(FRAME_W - 1));
  assign full = (count_reg == CW'(FRAME_W));

endmodule

// File: rtl/serial_frame_rx.sv
// sen/sd serial frame receiver writing address/data frames into a register bank.
// Define SERIAL_FRAME_PARITY_EN to add a trailing even-parity bit to every frame.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int AW         = 3,
  parameter int DW         = 18,
  parameter int NUM_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sen,
  input  logic             sd,
  output logic             RB_RW,
  output logic [AW-1:0]    RB_A,
  output logic [DW-1:0]    RB_D,
  output logic             done,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

`ifdef SERIAL_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_W = frame_w(AW, DW, PAR_EN);

  state_t             state_reg, state_next;
  logic               sh_start, sh_shift, sh_last, sh_full;
  logic [FRAME_W-1:0] sh_data;
  logic               parity_ok, write_ok;
  logic               wr, err;
  logic [CNT_W-1:0]   cnt_inc, cnt_after;
  logic               reached;

  frame_shift_reg #(.FRAME_W(FRAME_W)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .start (sh_start),
    .shift (sh_shift),
    .sd    (sd),
    .data  (sh_data),
    .last  (sh_last),
    .full  (sh_full)
  );

`ifdef SERIAL_FRAME_PARITY_EN
  // Even parity over address, data and the parity bit itself must XOR to zero.
  assign parity_ok = ~(^sh_data);
`else
  assign parity_ok = 1'b1;
`endif

  assign write_ok  = sh_full && parity_ok;
  assign cnt_inc   = (frame_cnt == {CNT_W{1'b1}}) ? frame_cnt : frame_cnt + CNT_W'(1);
  assign cnt_after = wr ? cnt_inc : frame_cnt;
  assign reached   = (cnt_after >= CNT_W'(NUM_FRAMES));

  always_comb begin
    state_next = state_reg;
    sh_start   = 1'b0;
    sh_shift   = 1'b0;
    wr         = 1'b0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!sen) begin
          sh_start   = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sen) begin
          err        = 1'b1;
          state_next = IDLE;
        end else begin
          sh_shift = 1'b1;
          if (sh_last) state_next = WRITE;
        end
      end
      WRITE: begin
        wr  = write_ok;
        err = !write_ok;
        // A still-low sen here means the sender overran the frame.
        if (!sen)         state_next = DRAIN;
        else if (reached) state_next = DONE;
        else              state_next = IDLE;
      end
      DRAIN: begin
        if (sen) begin
          err        = 1'b1;
          state_next = reached ? DONE : IDLE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      RB_RW     <= 1'b1;
      RB_A      <= '0;
      RB_D      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_reg <= state_next;
      RB_RW     <= !wr;
      frame_err <= err;
      frame_cnt <= cnt_after;
      done      <= (state_reg == DONE);
      if (wr) begin
        RB_A <= sh_data[FRAME_W-1 -: AW];
        RB_D <= sh_data[FRAME_W-1-AW -: DW];
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (AW=3, DW=18, NUM_FRAMES=8).
// Honours SERIAL_FRAME_PARITY_EN to add the parity frames.
module tb_serial_frame_rx;
  import serial_frame_pkg::*;

  localparam int AW = 3;
  localparam int DW = 18;
  localparam int NF = 8;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int FW = AW + DW + 1;
`else
  localparam int FW = AW + DW;
`endif

  logic             clk = 1'b0;
  logic             rst, sen, sd;
  logic             RB_RW;
  logic [AW-1:0]    RB_A;
  logic [DW-1:0]    RB_D;
  logic             done, frame_err;
  logic [CNT_W-1:0] frame_cnt;

  serial_frame_rx #(.AW(AW), .DW(DW), .NUM_FRAMES(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .sen       (sen),
    .sd        (sd),
    .RB_RW     (RB_RW),
    .RB_A      (RB_A),
    .RB_D      (RB_D),
    .done      (done),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;
    logic [CNT_W-1:0] c;
  } wr_t;

  wr_t  wr_q[$];
  wr_t  mon_e;
  int   err_pending = 0;
  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every bank write and every frame_err pulse must match an expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (RB_RW === 1'b0) begin
        if (wr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", RB_A, RB_D);
        end else begin
          mon_e = wr_q.pop_front();
          $display("write addr=%0h data=%05h cnt=%0d", RB_A, RB_D, frame_cnt);
          chk("wr_addr", 32'(RB_A), 32'(mon_e.a));
          chk("wr_data", 32'(RB_D), 32'(mon_e.d));
          chk("wr_cnt", 32'(frame_cnt), 32'(mon_e.c));
        end
      end
      if (frame_err === 1'b1) begin
        total++;
        if (err_pending == 0) begin
          bad++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else begin
          err_pending--;
          $display("frame_err pulse cnt=%0d", frame_cnt);
        end
      end
    end
  end

  function automatic logic [31:0] mk_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                           input logic flip);
    logic [AW+DW-1:0] p;
    p = {a, d};
`ifdef SERIAL_FRAME_PARITY_EN
    return 32'({p, (^p) ^ flip});
`else
    return 32'(p) | 32'(flip & 1'b0);
`endif
  endfunction

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      sen = 1'b0;
      sd  = bits[i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sd  = 1'b0;
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    exp_cnt++;
    e.a = a;
    e.d = d;
    e.c = CNT_W'(exp_cnt);
    wr_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    rst = 1'b1;
    sen = 1'b1;
    sd  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rb_rw", 32'(RB_RW), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("reset_rb_a", 32'(RB_A), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(1);

    // Basic frame with exact write latency.
    push_wr(3'b101, 18'h2A5C3);
    send_bits(mk_frame(3'b101, 18'h2A5C3, 1'b0), FW);
    idle(1);
    chk("latency_early_rb_rw", 32'(RB_RW), 32'd1);
    @(negedge clk);
    chk("latency_write_rb_rw", 32'(RB_RW), 32'd0);
    chk("latency_write_rb_a", 32'(RB_A), 32'd5);

    // Short frame: sen rises after 10 bits.
    err_pending++;
    send_bits(mk_frame(3'b011, 18'h15555, 1'b0), 10);
    idle(1);
    @(negedge clk);
    chk("short_err_pulse", 32'(frame_err), 32'd1);
    @(negedge clk);
    chk("short_err_width", 32'(frame_err), 32'd0);
    chk("short_cnt_hold", 32'(frame_cnt), 32'd1);

    push_wr(3'd2, 18'h12345);
    send_bits(mk_frame(3'd2, 18'h12345, 1'b0), FW);
    idle(1);

`ifdef SERIAL_FRAME_PARITY_EN
    err_pending++;
    send_bits(mk_frame(3'd4, 18'h0AAAA, 1'b1), FW);
    idle(2);
    chk("parity_bad_cnt", 32'(frame_cnt), 32'd2);
    push_wr(3'd4, 18'h0AAAA);
    send_bits(mk_frame(3'd4, 18'h0AAAA, 1'b0), FW);
    idle(1);
`endif

    // Overrun: sen held low 23 cycles.
    push_wr(3'd6, 18'h3FFFF);
    err_pending++;
    send_bits(mk_frame(3'd6, 18'h3FFFF, 1'b0), FW);
    send_bits(32'd2, 2);
    idle(1);
    @(negedge clk);
    chk("overrun_err_pulse", 32'(frame_err), 32'd1);
    idle(2);

    // Reset mid-frame discards the partial frame.
    send_bits(mk_frame(3'd1, 18'h00F0F, 1'b0), 12);
    @(negedge clk);
    rst = 1'b1;
    sen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    idle(3);
    chk("midreset_cnt", 32'(frame_cnt), 32'd0);
    chk("midreset_rb_rw", 32'(RB_RW), 32'd1);

    // Eight back-to-back frames with one idle cycle between them.
    for (int i = 0; i < NF; i++) begin
      d = 18'h10F0F ^ (18'(i) * 18'h00421);
      push_wr(3'(i), d);
      send_bits(mk_frame(3'(i), d, 1'b0), FW);
      idle(1);
    end
    @(negedge clk);
    chk("done_with_last_write", 32'(done), 32'd0);
    @(negedge clk);
    chk("done_set", 32'(done), 32'd1);
    chk("done_cnt", 32'(frame_cnt), 32'd8);

    // A ninth frame is ignored once done.
    send_bits(mk_frame(3'd3, 18'h3C3C3, 1'b0), FW);
    idle(4);
    chk("done_sticky", 32'(done), 32'd1);
    chk("done_cnt_hold", 32'(frame_cnt), 32'd8);
    chk("pending_writes", 32'(wr_q.size()), 32'd0);
    chk("pending_errs", 32'(err_pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
